pipeline_stall_ctrl: RTL and testbench

PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

---
 rtl/pipeline_stall_ctrl_pkg.sv | 13 +
 rtl/pipeline_stall_ctrl.sv | 104 ++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared pipeline definitions: stall-controller FSM encoding, multiply/divide
// latency default and the hard-wired zero register.
package pipeline_stall_ctrl_pkg;

  typedef enum logic [0:0] {
    StRun,
    StMdBusy
  } md_state_e;

  localparam int unsigned MulDivCyclesDefault = 32;
  localparam logic [4:0] RegZero = 5'd0;

endpackage

// File: rtl/pipeline_stall_ctrl.sv
// Hazard detection and stall/flush control for the 5-stage pipeline, including
// tracking of the multi-cycle HI/LO multiply/divide unit.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int unsigned MULDIV_CYCLES = MulDivCyclesDefault
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  IF_ID_rs,
  input  logic [4:0]  IF_ID_rt,
  input  logic        IF_ID_is_branch,
  input  logic        IF_ID_is_muldiv,
  input  logic        IF_ID_reads_hilo,
  input  logic [4:0]  ID_EX_dst,
  input  logic        ID_EX_reg_write,
  input  logic        ID_EX_mem_read,
  input  logic [4:0]  EX_MEM_rd,
  input  logic        EX_MEM_mem_read,
  input  logic        branch_taken,
  output logic        pc_write,
  output logic        IF_ID_write,
  output logic        IF_ID_flush,
  output logic        ID_EX_flush,
  output logic        md_busy,
  output logic [15:0] stall_cycles
);

  localparam logic [5:0] MdLoad = 6'(MULDIV_CYCLES - 1);

  md_state_e   state_q, state_d;
  logic [5:0]  md_cnt_q, md_cnt_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;

  logic ex_dst_match, mem_rd_match;
  logic load_use_haz, branch_ex_haz, branch_mem_haz, hilo_haz;
  logic stall;

  assign md_busy = (state_q == StMdBusy);

  assign ex_dst_match  = (ID_EX_dst != RegZero) &&
                         ((ID_EX_dst == IF_ID_rs) || (ID_EX_dst == IF_ID_rt));
  assign mem_rd_match  = (EX_MEM_rd != RegZero) &&
                         ((EX_MEM_rd == IF_ID_rs) || (EX_MEM_rd == IF_ID_rt));

  assign load_use_haz   = ID_EX_mem_read && ex_dst_match;
  assign branch_ex_haz  = IF_ID_is_branch && ID_EX_reg_write && ex_dst_match;
  assign branch_mem_haz = IF_ID_is_branch && EX_MEM_mem_read && mem_rd_match;
  assign hilo_haz       = md_busy && (IF_ID_is_muldiv || IF_ID_reads_hilo);

  // Masking with rst_n keeps the pipeline enabled and unflushed during reset.
  assign stall = rst_n && (load_use_haz || branch_ex_haz || branch_mem_haz || hilo_haz);

  assign pc_write     = !stall;
  assign IF_ID_write  = !stall;
  assign ID_EX_flush  = stall;
  assign IF_ID_flush  = rst_n && branch_taken && !stall;
  assign stall_cycles = stall_cycles_q;

  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    unique case (state_q)
      StRun: begin
        if (IF_ID_is_muldiv && !stall) begin
          state_d  = StMdBusy;
          md_cnt_d = MdLoad;
        end
      end
      StMdBusy: begin
        // A muldiv waiting in ID is still stalled here, so it starts one cycle later.
        if (md_cnt_q == 6'd0) begin
          state_d = StRun;
        end else begin
          md_cnt_d = md_cnt_q - 6'd1;
        end
      end
      default: begin
        state_d  = StRun;
        md_cnt_d = 6'd0;
      end
    endcase
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StRun;
      md_cnt_q       <= 6'd0;
      stall_cycles_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      md_cnt_q       <= md_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: behavioural model compared every
// cycle, directed hazard scenarios with literal expectations, random traffic.
module tb_pipeline_stall_ctrl;

  localparam int MD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  IF_ID_rs, IF_ID_rt;
  logic        IF_ID_is_branch, IF_ID_is_muldiv, IF_ID_reads_hilo;
  logic [4:0]  ID_EX_dst;
  logic        ID_EX_reg_write, ID_EX_mem_read;
  logic [4:0]  EX_MEM_rd;
  logic        EX_MEM_mem_read;
  logic        branch_taken;
  logic        pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush, md_busy;
  logic [15:0] stall_cycles;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model state: busy cycles still to come, and the stall tally.
  int m_rem = 0;
  int m_sc = 0;

  pipeline_stall_ctrl #(.MULDIV_CYCLES(MD)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .IF_ID_rs        (IF_ID_rs),
    .IF_ID_rt        (IF_ID_rt),
    .IF_ID_is_branch (IF_ID_is_branch),
    .IF_ID_is_muldiv (IF_ID_is_muldiv),
    .IF_ID_reads_hilo(IF_ID_reads_hilo),
    .ID_EX_dst       (ID_EX_dst),
    .ID_EX_reg_write (ID_EX_reg_write),
    .ID_EX_mem_read  (ID_EX_mem_read),
    .EX_MEM_rd       (EX_MEM_rd),
    .EX_MEM_mem_read (EX_MEM_mem_read),
    .branch_taken    (branch_taken),
    .pc_write        (pc_write),
    .IF_ID_write     (IF_ID_write),
    .IF_ID_flush     (IF_ID_flush),
    .ID_EX_flush     (ID_EX_flush),
    .md_busy         (md_busy),
    .stall_cycles    (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit uses(input logic [4:0] r);
    return (r != 5'd0) && (r == IF_ID_rs || r == IF_ID_rt);
  endfunction

  function automatic bit model_stall();
    bit haz;
    haz = (ID_EX_mem_read && uses(ID_EX_dst)) ||
          (IF_ID_is_branch && ID_EX_reg_write && uses(ID_EX_dst)) ||
          (IF_ID_is_branch && EX_MEM_mem_read && uses(EX_MEM_rd)) ||
          ((m_rem > 0) && (IF_ID_is_muldiv || IF_ID_reads_hilo));
    return rst_n && haz;
  endfunction

  always @(posedge clk) begin
    bit s;
    s = model_stall();
    if (!rst_n) begin
      m_rem = 0;
      m_sc  = 0;
    end else begin
      if (s && m_sc < 65535) m_sc = m_sc + 1;
      if (m_rem > 0) m_rem = m_rem - 1;
      else if (IF_ID_is_muldiv && !s) m_rem = MD;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit s;
      s = model_stall();
      check("pc_write", int'(pc_write), int'(!s));
      check("IF_ID_write", int'(IF_ID_write), int'(!s));
      check("ID_EX_flush", int'(ID_EX_flush), int'(s));
      check("IF_ID_flush", int'(IF_ID_flush), int'(rst_n && branch_taken && !s));
      check("md_busy", int'(md_busy), int'(m_rem > 0));
      check("stall_cycles", int'(stall_cycles), m_sc);
    end
  end

  task automatic idle();
    IF_ID_rs = 5'd0; IF_ID_rt = 5'd0;
    IF_ID_is_branch = 1'b0; IF_ID_is_muldiv = 1'b0; IF_ID_reads_hilo = 1'b0;
    ID_EX_dst = 5'd0; ID_EX_reg_write = 1'b0; ID_EX_mem_read = 1'b0;
    EX_MEM_rd = 5'd0; EX_MEM_mem_read = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    // Reset with hazards present: outputs must stay in the pass-through state.
    ID_EX_mem_read = 1'b1; ID_EX_dst = 5'd3; IF_ID_rs = 5'd3; branch_taken = 1'b1;
    cyc();
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_pc_write", int'(pc_write), 1);
    check("rst_ID_EX_flush", int'(ID_EX_flush), 0);
    check("rst_IF_ID_flush", int'(IF_ID_flush), 0);
    check("rst_stall_cycles", int'(stall_cycles), 0);
    check("rst_md_busy", int'(md_busy), 0);

    // lw $3 in EX, add using $3 in ID.
    cyc(); rst_n = 1'b1; idle();
    ID_EX_mem_read = 1'b1; ID_EX_reg_write = 1'b1; ID_EX_dst = 5'd3; IF_ID_rs = 5'd3;
    @(negedge clk);
    check("lu_pc_write", int'(pc_write), 0);
    check("lu_ID_EX_flush", int'(ID_EX_flush), 1);
    cyc(); idle(); IF_ID_rs = 5'd3; EX_MEM_rd = 5'd3; EX_MEM_mem_read = 1'b1;
    @(negedge clk);
    check("lu_release", int'(pc_write), 1);
    check("lu_count", int'(stall_cycles), 1);

    // lw $5 then beq $5,$0 taken: two stalls, then flush.
    cyc(); idle();
    ID_EX_mem_read = 1'b1; ID_EX_reg_write = 1'b1; ID_EX_dst = 5'd5;
    IF_ID_is_branch = 1'b1; IF_ID_rs = 5'd5; branch_taken = 1'b1;
    @(negedge clk);
    check("lb_ex_stall", int'(pc_write), 0);
    check("lb_ex_noflush", int'(IF_ID_flush), 0);
    cyc(); ID_EX_mem_read = 1'b0; ID_EX_reg_write = 1'b0; ID_EX_dst = 5'd0;
    EX_MEM_rd = 5'd5; EX_MEM_mem_read = 1'b1;
    @(negedge clk);
    check("lb_mem_stall", int'(ID_EX_flush), 1);
    cyc(); EX_MEM_rd = 5'd0; EX_MEM_mem_read = 1'b0;
    @(negedge clk);
    check("lb_go", int'(pc_write), 1);
    check("lb_flush", int'(IF_ID_flush), 1);
    check("lb_count", int'(stall_cycles), 3);

    // add $4 in EX, bne $4 in ID taken: one stall without flush.
    cyc(); idle();
    ID_EX_reg_write = 1'b1; ID_EX_dst = 5'd4;
    IF_ID_is_branch = 1'b1; IF_ID_rt = 5'd4; branch_taken = 1'b1;
    @(negedge clk);
    check("ab_stall", int'(pc_write), 0);
    check("ab_noflush", int'(IF_ID_flush), 0);
    cyc(); ID_EX_reg_write = 1'b0; ID_EX_dst = 5'd0; EX_MEM_rd = 5'd4;
    @(negedge clk);
    check("ab_flush", int'(IF_ID_flush), 1);
    check("ab_count", int'(stall_cycles), 4);

    // Destination $0 never stalls.
    cyc(); idle(); ID_EX_mem_read = 1'b1; ID_EX_reg_write = 1'b1;
    IF_ID_is_branch = 1'b1; EX_MEM_mem_read = 1'b1;
    @(negedge clk);
    check("zero_dst", int'(pc_write), 1);

    // mult then mflo: four busy cycles, mflo issues in cycle 5.
    cyc(); idle(); IF_ID_is_muldiv = 1'b1;
    @(negedge clk);
    check("mult_issue", int'(pc_write), 1);
    for (int i = 0; i < MD; i++) begin
      cyc(); idle(); IF_ID_reads_hilo = 1'b1;
      @(negedge clk);
      check("mflo_busy", int'(md_busy), 1);
      check("mflo_stall", int'(pc_write), 0);
    end
    cyc();
    @(negedge clk);
    check("mflo_issue_busy", int'(md_busy), 0);
    check("mflo_issue", int'(pc_write), 1);
    check("mflo_count", int'(stall_cycles), 8);

    // Back-to-back mult: the waiting one starts one cycle after busy drops.
    cyc(); idle(); IF_ID_is_muldiv = 1'b1;
    repeat (MD + 1) cyc();
    @(negedge clk);
    check("mm_restart_idle", int'(md_busy), 0);
    check("mm_restart_go", int'(pc_write), 1);
    cyc(); idle();
    @(negedge clk);
    check("mm_second_busy", int'(md_busy), 1);
    repeat (MD) cyc();

    // Reset during the 2nd busy cycle.
    cyc(); idle(); IF_ID_is_muldiv = 1'b1;
    cyc(); idle();
    cyc(); rst_n = 1'b0; IF_ID_reads_hilo = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", int'(md_busy), 1);
    check("rst_mid_pc_write", int'(pc_write), 1);
    cyc(); rst_n = 1'b1; idle();
    @(negedge clk);
    check("rst_mid_after_busy", int'(md_busy), 0);
    check("rst_mid_after_count", int'(stall_cycles), 0);

    // Random traffic over a small register set to make matches likely.
    for (int i = 0; i < 3000; i++) begin
      cyc();
      rst_n            = ($urandom_range(0, 99) != 0);
      IF_ID_rs         = 5'($urandom_range(0, 3));
      IF_ID_rt         = 5'($urandom_range(0, 3));
      IF_ID_is_branch  = ($urandom_range(0, 3) == 0);
      IF_ID_is_muldiv  = ($urandom_range(0, 7) == 0);
      IF_ID_reads_hilo = ($urandom_range(0, 7) == 0);
      ID_EX_dst        = 5'($urandom_range(0, 3));
      ID_EX_reg_write  = 1'($urandom_range(0, 1));
      ID_EX_mem_read   = ($urandom_range(0, 3) == 0);
      EX_MEM_rd        = 5'($urandom_range(0, 3));
      EX_MEM_mem_read  = ($urandom_range(0, 3) == 0);
      branch_taken     = 1'($urandom_range(0, 1));
    end

    // Saturation: hold a load-use stall until the counter pins at its maximum.
    cyc(); rst_n = 1'b0; idle();
    cyc(); rst_n = 1'b1;
    ID_EX_mem_read = 1'b1; ID_EX_dst = 5'd7; IF_ID_rt = 5'd7;
    repeat (65535 - 2) cyc();
    @(negedge clk);
    check("sat_near", int'(stall_cycles), 65533);
    repeat (3) cyc();
    @(negedge clk);
    check("sat_hold", int'(stall_cycles), 65535);
    cyc();
    @(negedge clk);
    check("sat_hold2", int'(stall_cycles), 65535);

    cyc(); idle();
    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
